// File: rtl/ram_pkg.sv
// Shared definitions for the RAM-side blocks around the 256x32 dual_port_ram.
//   RAM_ADDR_W / RAM_DATA_W / RAM_DEPTH : RAM geometry
//   ram_copy_state_e                    : copy engine FSM states
package ram_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ram_copy_state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Valid + address delay line that tracks RAM reads in flight.
// An entry pushed in cycle t appears at the tail in cycle t+DEPTH, which lines
// up with the read data of a read issued in cycle t on a RAM of read latency
// DEPTH.
//   clk, rst    : clock, asynchronous active-high reset (clears every stage)
//   push_valid  : a read is issued this cycle
//   push_addr   : address to attach to that read
//   tail_valid  : oldest entry is valid (its read data is on the RAM bus now)
//   tail_addr   : address attached to the oldest entry
//   pending     : valid entries exist behind the tail (pipe not yet draining
//                 its last entry)
module ram_rd_pipe #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              tail_valid,
  output logic [ADDR_W-1:0] tail_addr,
  output logic              pending
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= push_valid;
      addr_q[0]  <= push_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_addr  = addr_q[DEPTH-1];

  generate
    if (DEPTH > 1) begin : g_pending
      assign pending = |valid_q[DEPTH-2:0];
    end else begin : g_no_pending
      assign pending = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ram_copy_engine.sv
// Block-copy engine: moves `length` words from src_addr.. to dst_addr.. inside
// the dual_port_ram, reading on port A and writing on port B, one word/cycle.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : copy request, sampled only while idle
//   src_addr        : first source word
//   dst_addr        : first destination word
//   length          : word count 0..2**ADDR_W
//   busy            : copy in progress
//   done            : one-cycle pulse on completion (also for length 0)
//   error           : one-cycle pulse when a request is rejected
//   ram_addr_a      : RAM port-A read address
//   ram_data_a      : RAM port-A read data (READ_LATENCY cycles after address)
//   ram_addr_wr_b   : RAM port-B write address
//   ram_data_in_b   : RAM port-B write data
//   ram_we_b        : RAM port-B write enable
//   state_dbg       : current FSM state
//
// Handshake: start is a level sampled on a rising edge while busy=0; the
// outcome is exactly one of done/error, pulsed for one cycle. A start while
// busy=1 is dropped without any response.
module ram_copy_engine
  import ram_pkg::*;
#(
  parameter int ADDR_W       = RAM_ADDR_W,
  parameter int DATA_W       = RAM_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] ram_addr_a,
  input  logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_addr_wr_b,
  output logic [DATA_W-1:0] ram_data_in_b,
  output logic              ram_we_b,
  output ram_copy_state_e   state_dbg
);

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  ram_copy_state_e   state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W:0]   rd_cnt_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic              reject;
  logic              zero_done;
  logic              issue;
  logic              drain_done;

  logic              tail_valid;
  logic [ADDR_W-1:0] tail_addr;
  logic              pending;

  // Request validation works on the live inputs in the start cycle, so the
  // verdict is registered together with the latched operands. Once length is
  // known to be <= depth the ADDR_W+1 bit sums cannot overflow.
  logic [ADDR_W:0] src_end;
  logic [ADDR_W:0] dst_end;
  logic            req_bad;

  assign src_end = {1'b0, src_addr} + length;
  assign dst_end = {1'b0, dst_addr} + length;
  assign req_bad = (length > DEPTH_V) ||
                   (src_end > DEPTH_V) ||
                   (dst_end > DEPTH_V) ||
                   ((dst_addr > src_addr) && ({1'b0, dst_addr} < src_end));

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    reject     = 1'b0;
    zero_done  = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_bad) begin
            reject = 1'b1;
          end else if (length == '0) begin
            zero_done = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        issue = 1'b1;
        if (rd_cnt_q == CNT_ONE) state_d = DRAIN;
      end
      DRAIN: begin
        // The tail holds the last write this cycle when nothing is behind it.
        if (!pending) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_cnt_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= zero_done | drain_done;
      error_q <= reject;
      if (accept) begin
        rd_addr_q <= src_addr;
        wr_addr_q <= dst_addr;
        rd_cnt_q  <= length;
      end else if (issue) begin
        // rd_addr_q may step past the top word after the last read; it is
        // not used again before the next accept reloads it.
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
        wr_addr_q <= wr_addr_q + ADDR_W'(1);
        rd_cnt_q  <= rd_cnt_q - CNT_ONE;
      end
    end
  end

  ram_rd_pipe #(
    .DEPTH  (READ_LATENCY),
    .ADDR_W (ADDR_W)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (issue),
    .push_addr  (wr_addr_q),
    .tail_valid (tail_valid),
    .tail_addr  (tail_addr),
    .pending    (pending)
  );

  // Read data passes straight through to the write port; gating with
  // tail_valid keeps the write bus at zero when no write is in progress.
  assign ram_addr_a    = rd_addr_q;
  assign ram_we_b      = tail_valid;
  assign ram_addr_wr_b = tail_valid ? tail_addr : '0;
  assign ram_data_in_b = tail_valid ? ram_data_a : '0;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
module tb_ram_copy_engine;
  import ram_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  ram_addr_a;
  logic [31:0] ram_data_a;
  logic [7:0]  ram_addr_wr_b;
  logic [31:0] ram_data_in_b;
  logic        ram_we_b;
  ram_copy_state_e state_dbg;

  // host side of RAM port A (write only)
  logic        host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_data;

  always #5 clk = ~clk;

  ram_copy_engine #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .ram_addr_a    (ram_addr_a),
    .ram_data_a    (ram_data_a),
    .ram_addr_wr_b (ram_addr_wr_b),
    .ram_data_in_b (ram_data_in_b),
    .ram_we_b      (ram_we_b),
    .state_dbg     (state_dbg)
  );

  // RAM model: read latency 1, host port-A write wins collisions.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    ram_data_a <= mem[ram_addr_a];
    if (host_we) mem[host_addr] <= host_data;
    if (ram_we_b && !(host_we && host_addr == ram_addr_wr_b))
      mem[ram_addr_wr_b] <= ram_data_in_b;
  end

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];
  logic [31:0] gold [256];
  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int cur_streak = 0;
  int max_streak = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we_b) begin
        we_cnt++;
        cur_streak++;
        if (cur_streak > max_streak) max_streak = cur_streak;
        if (exp_q.size() == 0) check("wr_unexpected", 64'(ram_we_b), 64'd0);
        else check("wr", 64'({ram_addr_wr_b, ram_data_in_b}), 64'(exp_q.pop_front()));
      end else begin
        cur_streak = 0;
      end
      if (done)  done_cnt++;
      if (error) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_write(input int a, input logic [31:0] d);
    host_we = 1'b1; host_addr = 8'(a); host_data = d;
    gold[a] = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  // host_off: cycle (T+n) at which the host writes 0xA5A5A5A5 to the word the
  // engine writes in that same cycle (-1: none). spur_at: cycle at which a
  // stray start is driven while busy (-1: none).
  task automatic do_copy(input int src, input int dst, input int len,
                         input int host_off, input int spur_at);
    logic bad;
    int n, we0, done0, err0, haddr;
    logic [31:0] tmp [256];
    bad = (len > 256) || (src + len > 256) || (dst + len > 256) ||
          ((dst > src) && (dst < src + len));
    we0 = we_cnt; done0 = done_cnt; err0 = err_cnt;
    haddr = (host_off >= 0) ? dst + host_off - 2 : 0;
    if (!bad) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({8'(dst + i), gold[src + i]});
        tmp[i] = gold[src + i];
      end
      for (int i = 0; i < len; i++) gold[dst + i] = tmp[i];
      if (host_off >= 0) gold[haddr] = 32'hA5A5_A5A5;
    end
    start = 1'b1; src_addr = 8'(src); dst_addr = 8'(dst); length = 9'(len);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    if (bad || len == 0) begin
      check("err_pulse", 64'(error), 64'(bad));
      check("done_pulse", 64'(done), 64'(!bad));
      check("busy_idle", 64'(busy), 64'd0);
      @(negedge clk); #1;
      check("no_writes", 64'(we_cnt - we0), 64'd0);
      check("busy_idle2", 64'(busy), 64'd0);
    end else begin
      check("busy_on", 64'(busy), 64'd1);
      while (done !== 1'b1 && n < 600) begin
        if (n == host_off) begin
          host_we = 1'b1; host_addr = 8'(haddr); host_data = 32'hA5A5_A5A5;
        end else host_we = 1'b0;
        if (n == spur_at) begin
          start = 1'b1; src_addr = 8'd100; dst_addr = 8'd200; length = 9'd1;
        end else start = 1'b0;
        @(negedge clk);
        n++;
      end
      host_we = 1'b0; start = 1'b0;
      check("done_lat", 64'(n), 64'(len + 2));
      check("busy_off", 64'(busy), 64'd0);
      @(negedge clk); #1;
      check("n_writes", 64'(we_cnt - we0), 64'(len));
      check("n_done", 64'(done_cnt - done0), 64'd1);
      check("n_err", 64'(err_cnt - err0), 64'd0);
      check("exp_empty", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic reset_mid_copy();
    int n, done0;
    done0 = done_cnt;
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), gold[i]});
    start = 1'b1; src_addr = 8'd0; dst_addr = 8'd0; length = 9'd256;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    check("rst_we", 64'(ram_we_b), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_addr", 64'(ram_addr_wr_b), 64'd0);
    check("rst_pending", 64'(exp_q.size()), 64'd157);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("rst_no_done", 64'(done_cnt - done0), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int mism;
    int s, d, l;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    host_we = 1'b0; host_addr = '0; host_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy0", 64'(busy), 64'd0);
    check("rst_done0", 64'(done), 64'd0);
    check("rst_err0", 64'(error), 64'd0);
    check("rst_we0", 64'(ram_we_b), 64'd0);
    check("rst_addr_a0", 64'(ram_addr_a), 64'd0);
    check("rst_addr_b0", 64'(ram_addr_wr_b), 64'd0);
    check("rst_data_b0", 64'(ram_data_in_b), 64'd0);
    check("rst_state0", 64'(state_dbg), 64'(IDLE));
    rst = 1'b0;

    for (int k = 0; k < 256; k++) host_write(k, 32'(k));
    for (int i = 0; i < 8; i++) host_write(i, 32'h1000_0000 + 32'(i));

    // basic copy
    do_copy(0, 16, 8, -1, -1);
    for (int i = 0; i < 8; i++) check("t1_word", 64'(mem[16 + i]), 64'(32'h1000_0000 + 32'(i)));
    check("t1_word24", 64'(mem[24]), 64'd24);

    // forward overlap rejected
    do_copy(4, 6, 4, -1, -1);

    // backward overlap memmove
    for (int k = 0; k < 16; k++) host_write(k, 32'(k));
    do_copy(6, 4, 4, -1, -1);
    for (int i = 0; i < 4; i++) check("t3_word", 64'(mem[4 + i]), 64'(6 + i));

    // out of range, zero length
    do_copy(250, 0, 7, -1, -1);
    do_copy(10, 20, 0, -1, -1);

    // full-size self copy
    cur_streak = 0; max_streak = 0;
    do_copy(0, 0, 256, -1, -1);
    check("t5_streak", 64'(max_streak), 64'd256);

    // reset in the middle of a full copy
    reset_mid_copy();

    // host collision plus stray start while busy
    do_copy(0, 32, 8, 5, 3);
    check("t7_host_win", 64'(mem[35]), 64'hA5A5_A5A5);

    // random requests
    for (int r = 0; r < 8; r++) begin
      s = $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      l = $urandom_range(0, 24);
      do_copy(s, d, l, -1, -1);
    end

    mism = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) mism++;
    check("final_mem", 64'(mism), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
